// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sample feeder and the FIR top.
package fir_pkg;

  // Feeder control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  // Default datapath widths, shared with the FIR core top level.
  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH = 38;
  localparam int DEF_RES_WIDTH = 16;

endpackage

// File: rtl/fir_result_fifo.sv
// Small result FIFO; the head entry is visible combinationally on dout.
module fir_result_fifo #(
  parameter int DEPTH     = 4,
  parameter int RES_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [RES_WIDTH-1:0]       din,
  output logic [RES_WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [RES_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW:0]          count_reg;

  // Storage has no reset so it can map onto distributed or block memory.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign dout  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fir_sample_feeder.sv
// Feeds one sample at a time into the FIR core, then scales and queues its result.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH,
  parameter int RES_WIDTH = DEF_RES_WIDTH,
  parameter int SHIFT     = 15,
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [IN_WIDTH-1:0]  FIR_input,
  output logic                 input_valid,
  input  logic [OUT_WIDTH-1:0] FIR_output,
  input  logic                 output_valid,
  output logic [RES_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 sat_flag,
  output logic                 timeout_flag
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = OUT_WIDTH + 1;

  // Rounding constant and clamp limits, all in the guard-extended width.
  localparam logic [EW-1:0] RND  = {{(EW-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [EW-1:0] RMAX = {{(EW-RES_WIDTH+1){1'b0}}, {(RES_WIDTH-1){1'b1}}};
  localparam logic [EW-1:0] RMIN = {{(EW-RES_WIDTH+1){1'b1}}, {(RES_WIDTH-1){1'b0}}};

  state_t               state_reg, state_next;
  logic [TW-1:0]        timer_reg;
  logic [IN_WIDTH-1:0]  fir_input_reg;
  logic                 sat_reg;
  logic                 timeout_reg;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_empty;
  logic [RES_WIDTH-1:0] fifo_dout;
  logic                 push, pop, accept, timer_done;
  logic signed [EW-1:0] round_sum, shifted;
  logic [RES_WIDTH-1:0] res_value;
  logic                 res_sat;

  // Gated by rst so every output reads 0 while reset is held.
  assign s_ready    = rst && (state_reg == ST_IDLE) && (fifo_count < CW'(DEPTH));
  assign accept     = s_valid && s_ready;
  assign timer_done = (timer_reg == TW'(TIMEOUT - 1));
  assign push       = (state_reg == ST_WAIT) && output_valid;
  assign pop        = m_valid && m_ready;

  // Next-state logic; output_valid takes priority over the timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_SEND;
      ST_SEND: state_next = ST_WAIT;
      ST_WAIT: if (output_valid || timer_done) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Sample capture, wait timer and sticky status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fir_input_reg <= '0;
      timer_reg     <= '0;
      sat_reg       <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      if (accept) fir_input_reg <= s_data;
      if (state_reg == ST_SEND)      timer_reg <= '0;
      else if (state_reg == ST_WAIT) timer_reg <= timer_reg + 1'b1;
      if (push && res_sat) sat_reg <= 1'b1;
      if ((state_reg == ST_WAIT) && !output_valid && timer_done) timeout_reg <= 1'b1;
    end
  end

  // Round half-up, arithmetic shift, then clamp to the signed result range.
  always_comb begin
    round_sum = $signed({FIR_output[OUT_WIDTH-1], FIR_output}) + $signed(RND);
    shifted   = round_sum >>> SHIFT;
    res_sat   = 1'b0;
    res_value = shifted[RES_WIDTH-1:0];
    if (shifted > $signed(RMAX)) begin
      res_value = {1'b0, {(RES_WIDTH-1){1'b1}}};
      res_sat   = 1'b1;
    end else if (shifted < $signed(RMIN)) begin
      res_value = {1'b1, {(RES_WIDTH-1){1'b0}}};
      res_sat   = 1'b1;
    end
  end

  fir_result_fifo #(
    .DEPTH     (DEPTH),
    .RES_WIDTH (RES_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (res_value),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign FIR_input    = fir_input_reg;
  assign input_valid  = (state_reg == ST_SEND);
  assign m_valid      = !fifo_empty;
  assign m_data       = fifo_empty ? '0 : fifo_dout;
  assign sat_flag     = sat_reg;
  assign timeout_flag = timeout_reg;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed plus randomized bench for fir_sample_feeder with a behavioural scaling model.
module tb_fir_sample_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] FIR_input;
  logic        input_valid;
  logic [37:0] FIR_output;
  logic        output_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        sat_flag;
  logic        timeout_flag;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  bit          sat_exp = 0;

  fir_sample_feeder dut (
    .clk          (clk),
    .rst          (rst),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .FIR_input    (FIR_input),
    .input_valid  (input_valid),
    .FIR_output   (FIR_output),
    .output_valid (output_valid),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .sat_flag     (sat_flag),
    .timeout_flag (timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: r = floor((v + 2^14) / 2^15), clamped to signed 16 bits.
  task automatic ref_scale(input longint v, output logic [15:0] r, output bit s);
    longint t, q;
    t = v + 64'sd16384;
    if (t >= 0) q = t / 64'sd32768;
    else        q = -((-t + 64'sd32767) / 64'sd32768);
    s = 0;
    if (q > 32767)       begin q = 32767;  s = 1; end
    else if (q < -32768) begin q = -32768; s = 1; end
    r = q[15:0];
  endtask

  // Offer a sample, let it be accepted, check the SEND pulse, end in WAIT cycle 1.
  task automatic start_txn(input logic [15:0] sample);
    int n = 0;
    s_data  = sample;
    s_valid = 1'b1;
    while (!s_ready && n < 20) begin tick(); n++; end
    check("accept_ready", {63'b0, s_ready}, 64'd1);
    tick();
    s_valid = 1'b0;
    s_data  = 16'($urandom);
    check("send_pulse", {63'b0, input_valid}, 64'd1);
    check("send_data", {48'b0, FIR_input}, {48'b0, sample});
    tick();
    check("pulse_once", {63'b0, input_valid}, 64'd0);
    check("wait_no_ready", {63'b0, s_ready}, 64'd0);
  endtask

  task automatic do_txn(input logic [15:0] sample, input longint v, input int lat, input bit pop_at_push);
    logic [15:0] r;
    logic [15:0] head;
    bit          s;
    start_txn(sample);
    repeat (lat - 1) tick();
    check("fir_input_held", {48'b0, FIR_input}, {48'b0, sample});
    FIR_output   = v[37:0];
    output_valid = 1'b1;
    if (pop_at_push) begin
      head = exp_q.pop_front();
      check("pp_valid", {63'b0, m_valid}, 64'd1);
      check("pp_data", {48'b0, m_data}, {48'b0, head});
      m_ready = 1'b1;
    end
    tick();
    output_valid = 1'b0;
    m_ready      = 1'b0;
    FIR_output   = 38'($urandom);
    ref_scale(v, r, s);
    exp_q.push_back(r);
    sat_exp = sat_exp | s;
    check("push_valid", {63'b0, m_valid}, 64'd1);
    check("sat_flag", {63'b0, sat_flag}, {63'b0, sat_exp});
    $display("txn sample=%h fir=%0d lat=%0d exp=%h", sample, v, lat, r);
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] head;
    head = exp_q.pop_front();
    check({tag, "_valid"}, {63'b0, m_valid}, 64'd1);
    check({tag, "_data"}, {48'b0, m_data}, {48'b0, head});
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    longint v;
    rst = 1'b0; s_data = '0; s_valid = 1'b0; FIR_output = '0; output_valid = 1'b0; m_ready = 1'b0;
    #1;
    check("rst_s_ready", {63'b0, s_ready}, 64'd0);
    check("rst_m_valid", {63'b0, m_valid}, 64'd0);
    check("rst_input_valid", {63'b0, input_valid}, 64'd0);
    check("rst_flags", {62'b0, sat_flag, timeout_flag}, 64'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("idle_ready", {63'b0, s_ready}, 64'd1);

    // Single sample with a long FIR latency.
    do_txn(16'h1234, 64'sd98304, 100, 0);
    check("single_data", {48'b0, m_data}, 64'd3);
    pop_check("single");
    check("single_empty", {63'b0, m_valid}, 64'd0);

    // Half-up rounding cases.
    do_txn(16'h0001, 64'sd16384, 3, 0);   pop_check("rnd_a");
    do_txn(16'h0002, 64'sd49152, 3, 0);   pop_check("rnd_b");
    do_txn(16'h0003, -64'sd49152, 3, 0);  pop_check("rnd_c");
    do_txn(16'h0004, -64'sd98304, 3, 0);  pop_check("rnd_d");
    check("no_sat_yet", {63'b0, sat_flag}, 64'd0);

    // Saturation both ways; flag stays sticky.
    do_txn(16'h0005, 64'sd2147483648, 2, 0);  pop_check("sat_pos");
    do_txn(16'h0006, -64'sd2147483648, 2, 0); pop_check("sat_neg");
    do_txn(16'h0007, 64'sd0, 2, 0);           pop_check("sat_zero");
    check("sat_sticky", {63'b0, sat_flag}, 64'd1);

    // Randomized samples, results and latencies.
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) v = longint'($signed(38'({$urandom, $urandom})));
      else            v = longint'(int'($urandom)) >>> $urandom_range(0, 16);
      do_txn(16'($urandom), v, int'($urandom_range(1, 12)), 0);
      pop_check("rand");
    end

    // Simultaneous push and pop.
    do_txn(16'h00a1, 64'sd327680, 4, 0);
    do_txn(16'h00a2, -64'sd655360, 4, 1);
    pop_check("pushpop");
    check("pushpop_empty", {63'b0, m_valid}, 64'd0);

    // Backpressure: fill the FIFO, then a fifth sample must stall.
    for (int i = 0; i < 4; i++) do_txn(16'(16'h0b00 + i), longint'(i) * 64'sd65536, 2, 0);
    s_data  = 16'h0bff;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("full_no_ready", {63'b0, s_ready}, 64'd0);
      tick();
    end
    s_valid = 1'b0;
    pop_check("bp_pulse");
    check("bp_ready_back", {63'b0, s_ready}, 64'd1);
    for (int i = 0; i < 3; i++) pop_check("bp_drain");
    check("bp_empty", {63'b0, m_valid}, 64'd0);

    // Timeout: no FIR response.
    start_txn(16'h0c01);
    repeat (254) tick();
    check("to_not_yet", {63'b0, timeout_flag}, 64'd0);
    tick();
    check("to_flag", {63'b0, timeout_flag}, 64'd1);
    check("to_ready", {63'b0, s_ready}, 64'd1);
    check("to_no_push", {63'b0, m_valid}, 64'd0);
    FIR_output = 38'd98304; output_valid = 1'b1;
    tick();
    output_valid = 1'b0;
    check("late_ignored", {63'b0, m_valid}, 64'd0);

    // Reset in the middle of WAIT with a result queued.
    do_txn(16'h0d01, 64'sd65536, 2, 0);
    start_txn(16'h0d02);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("mid_rst_outputs", {18'b0, s_ready, input_valid, FIR_input, m_valid, m_data, sat_flag, timeout_flag}, 64'd0);
    exp_q.delete();
    sat_exp = 0;
    tick(); tick();
    rst = 1'b1;
    FIR_output = 38'd98304; output_valid = 1'b1;
    tick();
    output_valid = 1'b0;
    check("stale_ignored", {63'b0, m_valid}, 64'd0);
    do_txn(16'h0d03, 64'sd98304, 5, 0);
    pop_check("post_rst");
    check("post_rst_flags", {62'b0, sat_flag, timeout_flag}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
